// File: rtl/mchan_ipa_pkg.sv
// mchan_ipa_pkg: shared state, descriptor and width constants for burst_splitter_ipa
`ifndef MCHAN_LEN_WIDTH
`define MCHAN_LEN_WIDTH 16
`endif
`ifndef MCHAN_OPC_WIDTH
`define MCHAN_OPC_WIDTH 3
`endif
package mchan_ipa_pkg;
  localparam int TCDM_AW = 12;
  localparam int EXT_AW = 29;
  localparam int LEN_W = `MCHAN_LEN_WIDTH;
  localparam int OPC_W = `MCHAN_OPC_WIDTH;
  localparam int NB_TRANS = 4;
  localparam int SID_W = $clog2(NB_TRANS);
  localparam int BURST_BYTES = 64;
  localparam int BURST_LEN_W = $clog2(BURST_BYTES);
  typedef enum logic {IDLE, SPLIT} state_t;
  typedef struct packed {
    logic [BURST_LEN_W-1:0] len;
    logic [OPC_W-1:0] opc;
    logic [SID_W-1:0] sid;
    logic [TCDM_AW-1:0] tcdm_add;
    logic [EXT_AW-1:0] ext_add;
    logic last;
  } burst_t;
endpackage

// File: rtl/burst_size_calc_ipa.sv
// burst_size_calc_ipa: bytes in the next burst, clipped to the remaining length and the external boundary
module burst_size_calc_ipa #(
  parameter int REM_W = 17,
  parameter int BURST_LENGTH = 64,
  localparam int BW = $clog2(BURST_LENGTH)
) (
  input  logic [REM_W-1:0] rem,
  input  logic [BW-1:0]    ext_off,
  input  logic             inc,
  output logic [BW:0]      size
);
  logic [BW:0] lim;
  always_comb begin
    lim = inc ? (BW+1)'(BURST_LENGTH) - {1'b0, ext_off} : (BW+1)'(BURST_LENGTH);
    size = rem < REM_W'(lim) ? rem[BW:0] : lim;
  end
endmodule

// File: rtl/burst_splitter_ipa.sv
// burst_splitter_ipa: splits linear commands into boundary-aligned bursts; MCHAN_BURST_SPLIT_CNT_EN adds a granted-burst counter
module burst_splitter_ipa
  import mchan_ipa_pkg::*;
#(
  parameter int TCDM_ADD_WIDTH = TCDM_AW,
  parameter int EXT_ADD_WIDTH = EXT_AW,
  parameter int MCHAN_LEN_WIDTH = LEN_W,
  parameter int MCHAN_OPC_WIDTH = OPC_W,
  parameter int NB_TRANSFERS = NB_TRANS,
  parameter int TRANS_SID_WIDTH = $clog2(NB_TRANSFERS),
  parameter int MCHAN_BURST_LENGTH = BURST_BYTES,
  parameter int BURST_LEN_WIDTH = $clog2(MCHAN_BURST_LENGTH)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cmd_req_i,
  output logic                       cmd_gnt_o,
  input  logic [MCHAN_LEN_WIDTH-1:0] cmd_len_i,
  input  logic [MCHAN_OPC_WIDTH-1:0] cmd_opc_i,
  input  logic                       cmd_inc_i,
  input  logic [TRANS_SID_WIDTH-1:0] cmd_sid_i,
  input  logic [TCDM_ADD_WIDTH-1:0]  tcdm_add_i,
  input  logic [EXT_ADD_WIDTH-1:0]   ext_add_i,
  output logic                       burst_req_o,
  input  logic                       burst_gnt_i,
  output logic [BURST_LEN_WIDTH-1:0] burst_len_o,
  output logic [MCHAN_OPC_WIDTH-1:0] burst_opc_o,
  output logic [TRANS_SID_WIDTH-1:0] burst_sid_o,
  output logic [TCDM_ADD_WIDTH-1:0]  burst_tcdm_add_o,
  output logic [EXT_ADD_WIDTH-1:0]   burst_ext_add_o,
  output logic                       burst_last_o,
  output logic                       busy_o
`ifdef MCHAN_BURST_SPLIT_CNT_EN
  ,
  input  logic                       burst_cnt_clr_i,
  output logic [15:0]                burst_cnt_o
`endif
);
  state_t state, state_n;
  logic [MCHAN_LEN_WIDTH:0] rem;
  logic [MCHAN_OPC_WIDTH-1:0] opc;
  logic [TRANS_SID_WIDTH-1:0] sid;
  logic inc;
  logic [TCDM_ADD_WIDTH-1:0] tcdm;
  logic [EXT_ADD_WIDTH-1:0] ext;
  logic [BURST_LEN_WIDTH:0] size, size_m1;
  logic hs, done, cmd_hs;
  burst_t burst;

  burst_size_calc_ipa #(
    .REM_W(MCHAN_LEN_WIDTH + 1),
    .BURST_LENGTH(MCHAN_BURST_LENGTH)
  ) u_size (
    .rem(rem),
    .ext_off(ext[BURST_LEN_WIDTH-1:0]),
    .inc(inc),
    .size(size)
  );

  assign burst_req_o = state == SPLIT;
  assign busy_o = state == SPLIT;
  assign hs = burst_req_o & burst_gnt_i;
  assign done = hs & burst.last;
  assign cmd_gnt_o = (state == IDLE) | done;
  assign cmd_hs = cmd_req_i & cmd_gnt_o;

  always_comb begin
    size_m1 = size - 1'b1;
    burst.len = busy_o ? size_m1[BURST_LEN_WIDTH-1:0] : '0;
    burst.opc = opc;
    burst.sid = sid;
    burst.tcdm_add = tcdm;
    burst.ext_add = ext;
    burst.last = busy_o && rem == (MCHAN_LEN_WIDTH+1)'(size);
  end

  assign burst_len_o = burst.len;
  assign burst_opc_o = burst.opc;
  assign burst_sid_o = burst.sid;
  assign burst_tcdm_add_o = burst.tcdm_add;
  assign burst_ext_add_o = burst.ext_add;
  assign burst_last_o = burst.last;

  always_comb begin
    state_n = cmd_hs ? SPLIT : done ? IDLE : state;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_n;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem <= '0;
      opc <= '0;
      sid <= '0;
      inc <= 1'b0;
      tcdm <= '0;
      ext <= '0;
    end else if (cmd_hs) begin
      rem <= {1'b0, cmd_len_i} + 1'b1;
      opc <= cmd_opc_i;
      sid <= cmd_sid_i;
      inc <= cmd_inc_i;
      tcdm <= tcdm_add_i;
      ext <= ext_add_i;
    end else if (hs) begin
      rem <= rem - (MCHAN_LEN_WIDTH+1)'(size);
      tcdm <= inc ? tcdm + TCDM_ADD_WIDTH'(size) : tcdm;
      ext <= inc ? ext + EXT_ADD_WIDTH'(size) : ext;
    end
  end

`ifdef MCHAN_BURST_SPLIT_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i || burst_cnt_clr_i) burst_cnt_o <= '0;
    else if (hs && burst_cnt_o != 16'hFFFF) burst_cnt_o <= burst_cnt_o + 1'b1;
  end
`else
`endif
endmodule

// File: tb/tb_burst_splitter_ipa.sv
// tb_burst_splitter_ipa: randomized and directed checking of burst_splitter_ipa against a queue-based model
module tb_burst_splitter_ipa;
  import mchan_ipa_pkg::*;
  logic clk = 0, rst = 1;
  logic cmd_req = 0, cmd_gnt, cmd_inc = 0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [OPC_W-1:0] cmd_opc = '0;
  logic [SID_W-1:0] cmd_sid = '0;
  logic [TCDM_AW-1:0] tcdm_add = '0;
  logic [EXT_AW-1:0] ext_add = '0;
  logic burst_req, burst_gnt = 0, burst_last, busy;
  logic [BURST_LEN_W-1:0] burst_len;
  logic [OPC_W-1:0] burst_opc;
  logic [SID_W-1:0] burst_sid;
  logic [TCDM_AW-1:0] burst_tcdm;
  logic [EXT_AW-1:0] burst_ext;
  int checks = 0, failures = 0, gnt_mode = 2;
  burst_t act, hold, snap;
  burst_t q[$], log_q[$];
  bit hold_ok = 0;

  burst_splitter_ipa dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_req_i(cmd_req), .cmd_gnt_o(cmd_gnt), .cmd_len_i(cmd_len), .cmd_opc_i(cmd_opc),
    .cmd_inc_i(cmd_inc), .cmd_sid_i(cmd_sid), .tcdm_add_i(tcdm_add), .ext_add_i(ext_add),
    .burst_req_o(burst_req), .burst_gnt_i(burst_gnt), .burst_len_o(burst_len),
    .burst_opc_o(burst_opc), .burst_sid_o(burst_sid), .burst_tcdm_add_o(burst_tcdm),
    .burst_ext_add_o(burst_ext), .burst_last_o(burst_last), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always_comb act = {burst_len, burst_opc, burst_sid, burst_tcdm, burst_ext, burst_last};

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic void gen(input logic [LEN_W-1:0] len, input logic [OPC_W-1:0] o,
                              input logic [SID_W-1:0] s, input logic inc,
                              input logic [TCDM_AW-1:0] t, input logic [EXT_AW-1:0] e);
    int unsigned rem, sz;
    burst_t b;
    rem = int'(len) + 1;
    while (rem != 0) begin
      sz = inc ? BURST_BYTES - int'(e[BURST_LEN_W-1:0]) : BURST_BYTES;
      if (rem < sz) sz = rem;
      b.len = BURST_LEN_W'(sz - 1);
      b.opc = o;
      b.sid = s;
      b.tcdm_add = t;
      b.ext_add = e;
      b.last = rem == sz;
      q.push_back(b);
      rem -= sz;
      if (inc) begin
        t += TCDM_AW'(sz);
        e += EXT_AW'(sz);
      end
    end
  endfunction

  function automatic burst_t lit(input int len, input int t, input int e, input bit last);
    burst_t b;
    b.len = BURST_LEN_W'(len);
    b.opc = 3'h5;
    b.sid = 2'd2;
    b.tcdm_add = TCDM_AW'(t);
    b.ext_add = EXT_AW'(e);
    b.last = last;
    return b;
  endfunction

  always @(posedge clk) begin
    #1;
    burst_gnt = gnt_mode == 2 ? 1'b1 : gnt_mode == 1 ? 1'b0 : ($urandom_range(0, 9) < 7);
  end

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      hold_ok = 0;
    end else begin
      chk("burst_req", 64'(burst_req), 64'(q.size() != 0));
      chk("busy", 64'(busy), 64'(q.size() != 0));
      chk("cmd_gnt", 64'(cmd_gnt), 64'(q.size() == 0 || (burst_gnt && q[0].last)));
      if (hold_ok && burst_req) chk("stable", 64'(act), 64'(hold));
      hold_ok = 0;
      if (burst_req && q.size() != 0) begin
        chk("burst", 64'(act), 64'(q[0]));
        if (burst_gnt) begin
          log_q.push_back(act);
          void'(q.pop_front());
        end else begin
          hold = act;
          hold_ok = 1;
        end
      end
      if (cmd_req && cmd_gnt) gen(cmd_len, cmd_opc, cmd_sid, cmd_inc, tcdm_add, ext_add);
    end
  end

  task automatic send(input logic [LEN_W-1:0] l, input logic [OPC_W-1:0] o, input logic [SID_W-1:0] s,
                      input logic i, input logic [TCDM_AW-1:0] t, input logic [EXT_AW-1:0] e);
    int n = 0;
    logic g;
    cmd_req = 1;
    cmd_len = l;
    cmd_opc = o;
    cmd_sid = s;
    cmd_inc = i;
    tcdm_add = t;
    ext_add = e;
    do begin
      @(negedge clk);
      g = cmd_gnt;
      @(posedge clk);
      #1;
      n++;
    end while (!g && n < 3000);
    chk("cmd_accept", 64'(g), 64'(1));
    cmd_req = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 64'(q.size() != 0 || busy), 64'(0));
  endtask

  initial begin
    burst_t exp_lit[8];
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_req", 64'(burst_req), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_cmd_gnt", 64'(cmd_gnt), 64'(1));
    chk("rst_outs", 64'(act), 64'(0));
    @(posedge clk);
    #1;
    send(16'd127, 3'h5, 2'd2, 1'b1, 12'h040, 29'h1000_0000);
    wait_idle();
    send(16'd99, 3'h5, 2'd2, 1'b1, 12'h100, 29'h1000_0030);
    wait_idle();
    send(16'd69, 3'h5, 2'd2, 1'b0, 12'h200, 29'h1000_0004);
    wait_idle();
    send(16'd0, 3'h5, 2'd2, 1'b1, 12'h000, 29'h0000_003F);
    wait_idle();
    exp_lit[0] = lit(63, 'h040, 'h1000_0000, 0);
    exp_lit[1] = lit(63, 'h080, 'h1000_0040, 1);
    exp_lit[2] = lit(15, 'h100, 'h1000_0030, 0);
    exp_lit[3] = lit(63, 'h110, 'h1000_0040, 0);
    exp_lit[4] = lit(19, 'h150, 'h1000_0080, 1);
    exp_lit[5] = lit(63, 'h200, 'h1000_0004, 0);
    exp_lit[6] = lit(5, 'h200, 'h1000_0004, 1);
    exp_lit[7] = lit(0, 'h000, 'h0000_003F, 1);
    chk("lit_count", 64'(log_q.size()), 64'(8));
    for (int k = 0; k < 8; k++)
      if (k < log_q.size()) chk($sformatf("lit%0d", k), 64'(log_q[k]), 64'(exp_lit[k]));
    gnt_mode = 1;
    send(16'd127, 3'h1, 2'd1, 1'b1, 12'h300, 29'h0ABC_0000);
    @(negedge clk);
    snap = act;
    repeat (5) @(negedge clk);
    chk("bp_hold", 64'(act), 64'(snap));
    @(posedge clk);
    #1 gnt_mode = 2;
    send(16'd10, 3'h2, 2'd3, 1'b1, 12'h020, 29'h0123_4567);
    @(negedge clk);
    chk("b2b_first_ext", 64'(burst_ext), 64'(29'h0123_4567));
    chk("b2b_first_req", 64'(burst_req), 64'(1));
    @(posedge clk);
    #1;
    wait_idle();
    gnt_mode = 1;
    send(16'd300, 3'h3, 2'd0, 1'b1, 12'h000, 29'h0000_0010);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_mid_req", 64'(burst_req), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1 gnt_mode = 0;
    for (int k = 0; k < 40; k++) begin
      logic [LEN_W-1:0] l;
      logic [EXT_AW-1:0] e;
      l = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 1000)) : LEN_W'($urandom_range(0, 150));
      if (k == 20) l = '1;
      e = EXT_AW'($urandom);
      if (k % 10 == 0) e = {23'h7F_FFFF, 6'($urandom)};
      send(l, OPC_W'($urandom), SID_W'($urandom), 1'($urandom), TCDM_AW'($urandom), e);
    end
    wait_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
